l1_snoop_responder: RTL and testbench
=====================================

# l1_snoop_responder

Snoop-side responder for the L1 data cache: the bus-facing counterpart to the processor-side access path. It accepts snooped bus operations from other caches and looks up the addressed set across all data ways. It returns HIT/HITM/NOHIT, streams a modified line back to the bus when the snoop demands it, and then issues a single MESI state update for the array to apply. It sits between the shared-bus model and the data-cache array, alongside the processor-side LRU/select logic.

## Interface
Parameters:
- WAYS, 8, data-cache associativity
- TAG_W, 12, tag width
- WB_BEATS, 8, data beats per line writeback (power of two)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- snoop_valid  in  1  snoop request present
- snoop_ready  out  1  responder idle and accepting
- snoop_op  in  2  0 READ, 1 WRITE, 2 RWIM, 3 INVALIDATE
- snoop_tag  in  TAG_W  snooped tag
- lines_in  in  cache_line_t[WAYS]  current set contents (tag, MESI_bits, LRU), sampled at accept
- result_valid  out  1  one-cycle pulse, snoop_result valid
- snoop_result  out  2  0 NOHIT, 1 HIT, 2 HITM
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  bus accepts beat
- wb_beat  out  $clog2(WB_BEATS)  beat index
- wb_last  out  1  final beat
- update_valid  out  1  one-cycle pulse, apply MESI update
- update_way  out  $clog2(WAYS)  way to update
- update_mesi  out  2  new MESI state
- protocol_err  out  1  one-cycle pulse, illegal coherence condition

MESI encoding: 0 I, 1 S, 2 E, 3 M.

## Operation
- FSM states: IDLE, LOOKUP, RESPOND, WRITEBACK, UPDATE.
- IDLE: snoop_ready=1. Accept on snoop_valid & snoop_ready. Latch op, tag, and lines_in. Go to LOOKUP.
- LOOKUP: hit = tag match AND MESI_bits != I. If several ways hit, the lowest index wins and protocol_err pulses. Register way and state. Go to RESPOND.
- RESPOND: result_valid=1. Result is HITM if the hit way is M, HIT if it is E or S, NOHIT otherwise.
- Transitions out of RESPOND:
  - READ, hit M: WRITEBACK, then update to S.
  - READ, hit E/S: UPDATE to S (a pulse with S is still issued when already S).
  - RWIM, hit M: WRITEBACK, then update to I.
  - RWIM, hit E/S: UPDATE to I.
  - INVALIDATE, hit S: UPDATE to I.
  - INVALIDATE, hit E/M: protocol_err, no update, go to IDLE.
  - WRITE, any hit: result forced to NOHIT, protocol_err, IDLE.
  - Any miss: IDLE.
- WRITEBACK: wb_valid held high. wb_beat starts at 0 and increments on each wb_valid & wb_ready. wb_last=1 when wb_beat==WB_BEATS-1. The handshake on the last beat moves to UPDATE. wb_beat is never allowed to wrap.
- UPDATE: update_valid=1 for one cycle with update_way/update_mesi. Return to IDLE.
- LRU is never modified; only MESI_bits change.

## Timing
- Reset (rst high at a posedge): next cycle all outputs 0, FSM IDLE, beat counter 0. snoop_ready=1 from the first cycle with rst low.
- Reset mid-operation, including mid-writeback: abort immediately. No update_valid, no result_valid, wb_valid low the next cycle.
- Cycles relative to the accept edge:
  - +1: LOOKUP.
  - +2: RESPOND (result_valid).
  - +3: UPDATE, first WRITEBACK beat, or IDLE.
- Writeback: minimum WB_BEATS cycles with wb_ready tied high. Backpressure can stall indefinitely, and wb_beat, wb_last, and wb_valid stay stable while stalled. UPDATE occurs the cycle after the last beat's handshake.
- snoop_ready is low from the accept edge until the FSM re-enters IDLE. snoop_valid outside IDLE is ignored.
- lines_in is sampled only at accept; later changes do not affect the operation in flight.
- protocol_err pulses in LOOKUP (duplicate hit) or RESPOND (illegal op/state), and can pulse in both for one snoop.
- update_way and update_mesi are 0 whenever update_valid is 0.

## Test plan
- READ tag 0x1A3, way 5 E, rest I: result_valid/HIT at +2, update_valid way 5 mesi 1 at +3, no wb_valid, snoop_ready at +4.
- READ hit way 2 M, wb_ready=1: HITM at +2, wb_beat 0..7 on cycles +3..+10 with wb_last at beat 7, update way 2 mesi 1 at +11.
- RWIM hit way 0 M, wb_ready alternating 0/1 starting low: each beat held two cycles, 8 handshakes total, update way 0 mesi 0 after the last handshake.
- INVALIDATE with all ways I or tag mismatch: NOHIT at +2, no update, no protocol_err, snoop_ready=1 at +3.
- READ tag matching ways 1 and 6, both S: protocol_err at +1, HIT at +2, update way 1 mesi 1. Separately, WRITE hitting an S line: NOHIT, protocol_err, no update.
- rst asserted during writeback beat 3: next cycle all outputs 0 and snoop_ready=1 after release, no update_valid ever issued for that snoop.

Source files
------------

// File: rtl/l1_snoop_responder.sv
// Snoop responder for the L1 data cache: looks up a snooped tag across all ways, answers
// HIT/HITM/NOHIT, streams back a modified line if needed, then issues one MESI update.
module l1_snoop_responder #(
    parameter int WAYS     = 8,
    parameter int TAG_W    = 12,
    parameter int WB_BEATS = 8,
    parameter int LRU_W    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int LINE_W  = TAG_W + 2 + LRU_W,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int BEAT_W  = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     snoop_valid,
    output logic                     snoop_ready,
    input  logic [1:0]               snoop_op,
    input  logic [TAG_W-1:0]         snoop_tag,
    // Way i occupies lines_in[i*LINE_W +: LINE_W] as {tag, mesi, lru}.
    input  logic [WAYS*LINE_W-1:0]   lines_in,
    output logic                     result_valid,
    output logic [1:0]               snoop_result,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [BEAT_W-1:0]        wb_beat,
    output logic                     wb_last,
    output logic                     update_valid,
    output logic [WAY_W-1:0]         update_way,
    output logic [1:0]               update_mesi,
    output logic                     protocol_err,
    output logic [2:0]               state_dbg
);

    // Handshakes: a snoop transfers on a posedge with snoop_valid & snoop_ready; a writeback
    // beat transfers on a posedge with wb_valid & wb_ready, and wb_valid/wb_beat/wb_last hold
    // steady until that beat transfers.

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RWIM  = 2'd2;
    localparam logic [1:0] OP_INVAL = 2'd3;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [1:0] RES_NOHIT = 2'd0;
    localparam logic [1:0] RES_HIT   = 2'd1;
    localparam logic [1:0] RES_HITM  = 2'd2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WB_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_RESPOND   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_UPDATE    = 3'd4
    } state_t;

    state_t state;

    logic [1:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_arr_q [WAYS];
    logic [1:0]       mesi_arr_q [WAYS];

    logic [WAY_W-1:0] way_q;
    logic [1:0]       upd_mesi_q;
    logic             go_wb_q;
    logic             go_upd_q;

    logic [WAYS-1:0]  in_match;
    logic [WAYS-1:0]  q_match;
    logic             in_dup;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic [1:0]       lk_mesi;
    logic [1:0]       lk_result;
    logic             lk_err;
    logic             lk_wb;
    logic             lk_upd;
    logic [1:0]       lk_upd_mesi;
    logic             unused_lru;

    assign snoop_ready = (state == S_IDLE) && !rst;
    assign state_dbg   = state;
    assign unused_lru  = ^lines_in;

    always_comb begin
        in_match = '0;
        q_match  = '0;
        for (int i = 0; i < WAYS; i++) begin
            in_match[i] = (lines_in[i*LINE_W + 2 + LRU_W +: TAG_W] == snoop_tag) &&
                          (lines_in[i*LINE_W + LRU_W +: 2] != MESI_I);
            q_match[i]  = (tag_arr_q[i] == tag_q) && (mesi_arr_q[i] != MESI_I);
        end
    end

    // More than one valid way holding the same tag is a coherence violation.
    assign in_dup = (in_match & (in_match - WAYS'(1))) != '0;
    assign lk_hit = |q_match;

    always_comb begin
        lk_way  = '0;
        lk_mesi = MESI_I;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (q_match[i]) begin
                lk_way  = WAY_W'(i);
                lk_mesi = mesi_arr_q[i];
            end
        end
    end

    always_comb begin
        lk_result   = RES_NOHIT;
        lk_err      = 1'b0;
        lk_wb       = 1'b0;
        lk_upd      = 1'b0;
        lk_upd_mesi = MESI_I;
        if (lk_hit) begin
            case (op_q)
                OP_READ: begin
                    lk_result   = (lk_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    lk_wb       = (lk_mesi == MESI_M);
                    lk_upd      = (lk_mesi != MESI_M);
                    lk_upd_mesi = MESI_S;
                end
                OP_RWIM: begin
                    lk_result   = (lk_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    lk_wb       = (lk_mesi == MESI_M);
                    lk_upd      = (lk_mesi != MESI_M);
                    lk_upd_mesi = MESI_I;
                end
                OP_INVAL: begin
                    lk_result   = (lk_mesi == MESI_M) ? RES_HITM : RES_HIT;
                    lk_upd      = (lk_mesi == MESI_S);
                    lk_err      = (lk_mesi != MESI_S);
                    lk_upd_mesi = MESI_I;
                end
                OP_WRITE: begin
                    // Another cache writing a line we hold means coherence already broke.
                    lk_result = RES_NOHIT;
                    lk_err    = 1'b1;
                end
                default: begin
                    lk_result = RES_NOHIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= OP_READ;
            tag_q        <= '0;
            way_q        <= '0;
            upd_mesi_q   <= MESI_I;
            go_wb_q      <= 1'b0;
            go_upd_q     <= 1'b0;
            result_valid <= 1'b0;
            snoop_result <= RES_NOHIT;
            wb_valid     <= 1'b0;
            wb_beat      <= '0;
            wb_last      <= 1'b0;
            update_valid <= 1'b0;
            update_way   <= '0;
            update_mesi  <= MESI_I;
            protocol_err <= 1'b0;
            for (int i = 0; i < WAYS; i++) begin
                tag_arr_q[i]  <= '0;
                mesi_arr_q[i] <= MESI_I;
            end
        end else begin
            result_valid <= 1'b0;
            snoop_result <= RES_NOHIT;
            protocol_err <= 1'b0;
            update_valid <= 1'b0;
            update_way   <= '0;
            update_mesi  <= MESI_I;
            case (state)
                S_IDLE: begin
                    if (snoop_valid) begin
                        op_q         <= snoop_op;
                        tag_q        <= snoop_tag;
                        protocol_err <= in_dup;
                        for (int i = 0; i < WAYS; i++) begin
                            tag_arr_q[i]  <= lines_in[i*LINE_W + 2 + LRU_W +: TAG_W];
                            mesi_arr_q[i] <= lines_in[i*LINE_W + LRU_W +: 2];
                        end
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    result_valid <= 1'b1;
                    snoop_result <= lk_result;
                    protocol_err <= lk_err;
                    way_q        <= lk_way;
                    go_wb_q      <= lk_wb;
                    go_upd_q     <= lk_upd;
                    upd_mesi_q   <= lk_upd_mesi;
                    state        <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (go_wb_q) begin
                        wb_valid <= 1'b1;
                        wb_beat  <= '0;
                        wb_last  <= (LAST_BEAT == '0);
                        state    <= S_WRITEBACK;
                    end else if (go_upd_q) begin
                        update_valid <= 1'b1;
                        update_way   <= way_q;
                        update_mesi  <= upd_mesi_q;
                        state        <= S_UPDATE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_ready) begin
                        if (wb_last) begin
                            wb_valid     <= 1'b0;
                            wb_last      <= 1'b0;
                            wb_beat      <= '0;
                            update_valid <= 1'b1;
                            update_way   <= way_q;
                            update_mesi  <= upd_mesi_q;
                            state        <= S_UPDATE;
                        end else begin
                            wb_beat <= wb_beat + BEAT_W'(1);
                            wb_last <= ((wb_beat + BEAT_W'(1)) == LAST_BEAT);
                        end
                    end
                end
                S_UPDATE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Directed bench for l1_snoop_responder: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_l1_snoop_responder;

    localparam int WAYS     = 8;
    localparam int TAG_W    = 12;
    localparam int WB_BEATS = 8;
    localparam int LRU_W    = 3;
    localparam int LINE_W   = TAG_W + 2 + LRU_W;

    logic                   clk;
    logic                   rst;
    logic                   snoop_valid;
    logic                   snoop_ready;
    logic [1:0]             snoop_op;
    logic [TAG_W-1:0]       snoop_tag;
    logic [WAYS*LINE_W-1:0] lines_in;
    logic                   result_valid;
    logic [1:0]             snoop_result;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [2:0]             wb_beat;
    logic                   wb_last;
    logic                   update_valid;
    logic [2:0]             update_way;
    logic [1:0]             update_mesi;
    logic                   protocol_err;
    logic [2:0]             state_dbg;

    int checks = 0;
    int errors = 0;

    l1_snoop_responder #(.WAYS(WAYS), .TAG_W(TAG_W), .WB_BEATS(WB_BEATS), .LRU_W(LRU_W)) dut (
        .clk(clk), .rst(rst),
        .snoop_valid(snoop_valid), .snoop_ready(snoop_ready),
        .snoop_op(snoop_op), .snoop_tag(snoop_tag), .lines_in(lines_in),
        .result_valid(result_valid), .snoop_result(snoop_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_beat(wb_beat), .wb_last(wb_last),
        .update_valid(update_valid), .update_way(update_way), .update_mesi(update_mesi),
        .protocol_err(protocol_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no summary expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_way(input int w, input logic [TAG_W-1:0] tag, input logic [1:0] mesi,
                           input logic [LRU_W-1:0] lru);
        lines_in[w*LINE_W +: LINE_W] = {tag, mesi, lru};
    endtask

    // Presents one snoop and returns just after the accept edge (+1, LOOKUP).
    task automatic send_snoop(input logic [1:0] op, input logic [TAG_W-1:0] tag);
        snoop_op    = op;
        snoop_tag   = tag;
        snoop_valid = 1'b1;
        tick();
        snoop_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; snoop_valid = 1'b0; snoop_op = 2'd0; snoop_tag = '0;
        lines_in = '0; wb_ready = 1'b0;
        tick(); tick();
        chk("rst_ready",   snoop_ready, 0);
        chk("rst_result",  result_valid, 0);
        chk("rst_wb",      wb_valid, 0);
        chk("rst_beat",    wb_beat, 0);
        chk("rst_update",  update_valid, 0);
        chk("rst_perr",    protocol_err, 0);
        chk("rst_state",   state_dbg, 0);
        rst = 1'b0;
        #1;
        chk("rel_ready", snoop_ready, 1);

        // READ, way 5 E; other ways hold the same tag but are Invalid.
        for (int w = 0; w < WAYS; w++) set_way(w, 12'h1A3, 2'd0, 3'(w));
        set_way(5, 12'h1A3, 2'd2, 3'd4);
        send_snoop(2'd0, 12'h1A3);
        chk("t1_p1_state", state_dbg, 1);
        chk("t1_p1_ready", snoop_ready, 0);
        chk("t1_p1_perr",  protocol_err, 0);
        // Changing the set after accept must not matter.
        set_way(5, 12'h1A3, 2'd0, 3'd4);
        set_way(3, 12'h1A3, 2'd3, 3'd1);
        tick();
        chk("t1_p2_rv",  result_valid, 1);
        chk("t1_p2_res", snoop_result, 1);
        tick();
        chk("t1_p3_uv",   update_valid, 1);
        chk("t1_p3_way",  update_way, 5);
        chk("t1_p3_mesi", update_mesi, 1);
        chk("t1_p3_wb",   wb_valid, 0);
        chk("t1_p3_rv",   result_valid, 0);
        tick();
        chk("t1_p4_ready", snoop_ready, 1);
        chk("t1_p4_uv",    update_valid, 0);
        chk("t1_p4_way",   update_way, 0);

        // READ, way 2 M, bus always ready.
        lines_in = '0;
        set_way(2, 12'h2B4, 2'd3, 3'd0);
        wb_ready = 1'b1;
        send_snoop(2'd0, 12'h2B4);
        tick();
        chk("t2_p2_res", snoop_result, 2);
        for (int i = 0; i < WB_BEATS; i++) begin
            tick();
            chk("t2_wb_valid", wb_valid, 1);
            chk("t2_wb_beat",  wb_beat, 32'(i));
            chk("t2_wb_last",  wb_last, (i == WB_BEATS - 1) ? 1 : 0);
            chk("t2_wb_nouv",  update_valid, 0);
        end
        tick();
        chk("t2_uv",   update_valid, 1);
        chk("t2_way",  update_way, 2);
        chk("t2_mesi", update_mesi, 1);
        chk("t2_wbv",  wb_valid, 0);
        wb_ready = 1'b0;
        tick();

        // RWIM, way 0 M, bus ready alternating low/high.
        lines_in = '0;
        set_way(0, 12'h777, 2'd3, 3'd7);
        send_snoop(2'd2, 12'h777);
        tick();
        chk("t3_res", snoop_result, 2);
        tick();
        for (int i = 0; i < WB_BEATS; i++) begin
            chk("t3_beat_a",  wb_beat, 32'(i));
            chk("t3_valid_a", wb_valid, 1);
            chk("t3_last_a",  wb_last, (i == WB_BEATS - 1) ? 1 : 0);
            tick();
            chk("t3_beat_stall", wb_beat, 32'(i));
            chk("t3_valid_stall", wb_valid, 1);
            wb_ready = 1'b1;
            tick();
            wb_ready = 1'b0;
        end
        chk("t3_uv",   update_valid, 1);
        chk("t3_way",  update_way, 0);
        chk("t3_mesi", update_mesi, 0);
        tick();

        // INVALIDATE: all ways I with matching tag, then a tag mismatch on an S line.
        for (int w = 0; w < WAYS; w++) set_way(w, 12'h0AA, 2'd0, 3'(w));
        send_snoop(2'd3, 12'h0AA);
        chk("t4_p1_perr", protocol_err, 0);
        tick();
        chk("t4_p2_rv",   result_valid, 1);
        chk("t4_p2_res",  snoop_result, 0);
        chk("t4_p2_perr", protocol_err, 0);
        tick();
        chk("t4_p3_ready", snoop_ready, 1);
        chk("t4_p3_uv",    update_valid, 0);
        set_way(3, 12'h055, 2'd1, 3'd0);
        send_snoop(2'd3, 12'h056);
        tick();
        chk("t4b_res", snoop_result, 0);
        tick();
        chk("t4b_ready", snoop_ready, 1);
        chk("t4b_uv",    update_valid, 0);

        // READ hitting ways 1 and 6, both S.
        lines_in = '0;
        set_way(1, 12'h3C0, 2'd1, 3'd2);
        set_way(6, 12'h3C0, 2'd1, 3'd5);
        send_snoop(2'd0, 12'h3C0);
        chk("t5_p1_perr", protocol_err, 1);
        tick();
        chk("t5_p2_res",  snoop_result, 1);
        chk("t5_p2_perr", protocol_err, 0);
        tick();
        chk("t5_p3_uv",   update_valid, 1);
        chk("t5_p3_way",  update_way, 1);
        chk("t5_p3_mesi", update_mesi, 1);
        tick();

        // WRITE hitting an S line.
        lines_in = '0;
        set_way(4, 12'h123, 2'd1, 3'd0);
        send_snoop(2'd1, 12'h123);
        chk("t6_p1_perr", protocol_err, 0);
        tick();
        chk("t6_p2_rv",   result_valid, 1);
        chk("t6_p2_res",  snoop_result, 0);
        chk("t6_p2_perr", protocol_err, 1);
        tick();
        chk("t6_p3_uv",    update_valid, 0);
        chk("t6_p3_ready", snoop_ready, 1);

        // INVALIDATE hitting S (update to I), then hitting E (error, no update).
        send_snoop(2'd3, 12'h123);
        tick();
        chk("t7_res", snoop_result, 1);
        tick();
        chk("t7_uv",   update_valid, 1);
        chk("t7_way",  update_way, 4);
        chk("t7_mesi", update_mesi, 0);
        tick();
        set_way(4, 12'h123, 2'd2, 3'd0);
        send_snoop(2'd3, 12'h123);
        tick();
        chk("t7b_res",  snoop_result, 1);
        chk("t7b_perr", protocol_err, 1);
        tick();
        chk("t7b_uv",    update_valid, 0);
        chk("t7b_ready", snoop_ready, 1);

        // Reset during writeback beat 3.
        lines_in = '0;
        set_way(7, 12'hABC, 2'd3, 3'd3);
        wb_ready = 1'b1;
        send_snoop(2'd0, 12'hABC);
        tick(); tick(); tick(); tick(); tick();
        chk("t8_beat3", wb_beat, 3);
        rst = 1'b1;
        tick();
        chk("t8_wb",    wb_valid, 0);
        chk("t8_beat",  wb_beat, 0);
        chk("t8_last",  wb_last, 0);
        chk("t8_uv",    update_valid, 0);
        chk("t8_rv",    result_valid, 0);
        chk("t8_state", state_dbg, 0);
        rst = 1'b0;
        wb_ready = 1'b0;
        #1;
        chk("t8_ready", snoop_ready, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t8_no_uv", update_valid, 0);
            chk("t8_no_wb", wb_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
